// File: rtl/axi_arb_pkg.sv
// Shared types and sizing helpers for the round-robin axi_master command-port arbiter.
package axi_arb_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    // Watchdog counter width; a disabled watchdog still needs a 1-bit counter.
    function automatic int unsigned tmr_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/axi_master_arbiter_if.sv
// Requester bus and axi_master command port seen by the arbiter.
interface axi_master_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    logic                  start_read;
    logic                  start_write;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         write_data;
    logic                  done;
    logic [DW-1:0]         read_data;

    // Arbiter view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, done, read_data,
        output ack, rsp_rdata, rsp_err, busy, start_read, start_write, addr, write_data
    );

    // Requesters plus axi_master view
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, done, read_data,
        input  ack, rsp_rdata, rsp_err, busy, start_read, start_write, addr, write_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, modulo NUM_REQ.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_gnt_idx_c,
    output logic               o_any_c
);
    int unsigned w_pos;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        o_gnt_idx_c = '0;
        o_any_c     = 1'b0;
        w_pos       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = (32'(i_ptr) + 32'(k)) % NUM_REQ;
            if (i_req[IDX_W'(w_pos)]) begin
                o_gnt_idx_c = IDX_W'(w_pos);
                o_any_c     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Round-robin sharing of one axi_master command port, one transaction in flight, watchdog-bounded.
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_DEFAULT
) (
    input logic                  M_AXI_ACLK,
    input logic                  M_AXI_ARESET,
    axi_master_arbiter_if.master bus
);
    localparam int unsigned DW       = C_M_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned TMR_W    = tmr_width(TIMEOUT_CYCLES);
    localparam logic        WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic               r_write, w_write_nxt;
    logic               r_tmo, w_tmo_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               r_done_q;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [DW-1:0]      r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_start_read, w_start_read_nxt;
    logic               r_start_write, w_start_write_nxt;
    logic [AW-1:0]      r_addr, w_addr_nxt;
    logic [DW-1:0]      r_write_data, w_write_data_nxt;

    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic               w_done_rise;

    assign w_done_rise = bus.done & ~r_done_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_gnt_idx_c (w_gnt_idx),
        .o_any_c     (w_gnt_any)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_write_nxt       = r_write;
        w_tmo_nxt         = r_tmo;
        w_timer_nxt       = r_timer;
        w_ack_nxt         = '0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_start_read_nxt  = 1'b0;
        w_start_write_nxt = 1'b0;
        w_addr_nxt        = r_addr;
        w_write_data_nxt  = r_write_data;

        unique case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    w_idx_nxt         = w_gnt_idx;
                    w_write_nxt       = bus.req_write[w_gnt_idx];
                    w_addr_nxt        = bus.req_addr[32'(w_gnt_idx) * AW +: AW];
                    w_write_data_nxt  = bus.req_wdata[32'(w_gnt_idx) * DW +: DW];
                    w_start_write_nxt = bus.req_write[w_gnt_idx];
                    w_start_read_nxt  = ~bus.req_write[w_gnt_idx];
                    w_state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = WAIT;
            end
            // A done edge on the expiry cycle takes priority over the watchdog.
            WAIT: begin
                if (w_done_rise) begin
                    w_rsp_rdata_nxt = r_write ? '0 : bus.read_data;
                    w_rsp_err_nxt   = 1'b0;
                    w_ack_nxt       = NUM_REQ'(1) << r_idx;
                    w_state_nxt     = RESP;
                end else if (WDOG_EN && (r_timer == TMR_LAST)) begin
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_tmo_nxt       = 1'b1;
                    w_ack_nxt       = NUM_REQ'(1) << r_idx;
                    w_state_nxt     = RESP;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            RESP: begin
                w_rr_ptr_nxt = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                w_state_nxt  = r_tmo ? DRAIN : IDLE;
            end
            // Swallow the late completion of a timed-out transaction before granting again.
            DRAIN: begin
                if (w_done_rise) begin
                    w_tmo_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_rr_ptr      <= '0;
            r_write       <= 1'b0;
            r_tmo         <= 1'b0;
            r_timer       <= '0;
            r_done_q      <= 1'b0;
            r_ack         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_addr        <= '0;
            r_write_data  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_write       <= w_write_nxt;
            r_tmo         <= w_tmo_nxt;
            r_timer       <= w_timer_nxt;
            r_done_q      <= bus.done;
            r_ack         <= w_ack_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_busy        <= w_busy_nxt;
            r_start_read  <= w_start_read_nxt;
            r_start_write <= w_start_write_nxt;
            r_addr        <= w_addr_nxt;
            r_write_data  <= w_write_data_nxt;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.busy        = r_busy;
    assign bus.start_read  = r_start_read;
    assign bus.start_write = r_start_write;
    assign bus.addr        = r_addr;
    assign bus.write_data  = r_write_data;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter with a behavioural axi_master/register-file stub.
module tb_axi_master_arbiter;
    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_master_arbiter_if #(.NUM_REQ(NR), .DW(DW), .AW(AW)) bus ();

    axi_master_arbiter #(
        .NUM_REQ            (NR),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Stub: answers a start pulse with a 1-cycle done after stub_lat+2 cycles; hang ignores starts.
    logic [31:0] mem [0:15];
    logic        stub_done = 1'b0;
    logic        tb_done   = 1'b0;
    logic        stub_hang = 1'b0;
    logic        stub_pend = 1'b0;
    logic        stub_wr   = 1'b0;
    int          stub_lat  = 2;
    int          stub_cnt  = 0;
    logic [3:0]  stub_a    = '0;
    logic [31:0] stub_wd   = '0;
    logic [31:0] stub_rdata = '0;

    assign bus.done      = stub_done | tb_done;
    assign bus.read_data = stub_rdata;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (rst) begin
            stub_pend <= 1'b0;
        end else if (bus.start_write || bus.start_read) begin
            if (!stub_hang) begin
                stub_pend <= 1'b1;
                stub_cnt  <= stub_lat;
                stub_wr   <= bus.start_write;
                stub_a    <= bus.addr[5:2];
                stub_wd   <= bus.write_data;
            end
        end else if (stub_pend) begin
            if (stub_cnt == 0) begin
                stub_done <= 1'b1;
                stub_pend <= 1'b0;
                if (stub_wr) mem[stub_a] <= stub_wd;
                else         stub_rdata  <= mem[stub_a];
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    int n_sw = 0;
    int n_sr = 0;
    int n_both = 0;
    always @(posedge clk) begin
        if (bus.start_write) n_sw <= n_sw + 1;
        if (bus.start_read)  n_sr <= n_sr + 1;
        if (bus.start_write && bus.start_read) n_both <= n_both + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_write[i]          = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_valid[i]          = 1'b1;
    endtask

    // Bounded wait for an ack; a==0 on return means the budget expired.
    task automatic wait_ack(input int budget, input bit keep, output logic [3:0] a,
                            output logic [31:0] d, output logic e, output int cyc);
        a = '0; d = '0; e = 1'b0; cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.ack != '0) begin
                a = bus.ack; d = bus.rsp_rdata; e = bus.rsp_err;
                if (!keep) bus.req_valid = bus.req_valid & ~bus.ack;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({bus.ack, bus.busy, bus.start_read, bus.start_write, bus.rsp_err} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: ack=%b busy=%b rd=%b wr=%b err=%b want all 0",
                     bus.ack, bus.busy, bus.start_read, bus.start_write, bus.rsp_err);
        end
        n_chk++;
        if (bus.addr !== 32'h0 || bus.write_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cmd: addr=%h wdata=%h want 0", bus.addr, bus.write_data);
        end
        n_chk++;
        if (bus.rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] a; logic [31:0] d; logic e; int c; int sw0; int sr0;
        sw0 = n_sw; sr0 = n_sr;
        @(negedge clk);
        set_req(0, 1'b1, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        n_chk++;
        if (bus.start_write !== 1'b1 || bus.start_read !== 1'b0) begin
            n_err++;
            $display("FAIL wr_start: wr=%b rd=%b want wr=1 rd=0", bus.start_write, bus.start_read);
        end
        n_chk++;
        if (bus.addr !== 32'h0 || bus.write_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_cmd: addr=%h wdata=%h want 0/deadbeef", bus.addr, bus.write_data);
        end
        wait_ack(50, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0001 || e !== 1'b0) begin
            n_err++;
            $display("FAIL wr_ack: ack=%b err=%b want 0001/0", a, e);
        end
        n_chk++;
        if (c !== 5) begin
            n_err++;
            $display("FAIL wr_latency: got %0d cycles want 5", c);
        end
        n_chk++;
        if (n_sw - sw0 !== 1 || n_sr - sr0 !== 0) begin
            n_err++;
            $display("FAIL wr_pulses: writes=%0d reads=%0d want 1/0", n_sw - sw0, n_sr - sr0);
        end
        sr0 = n_sr;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bus.start_read !== 1'b1 || bus.start_write !== 1'b0) begin
            n_err++;
            $display("FAIL rd_start: rd=%b wr=%b want rd=1 wr=0", bus.start_read, bus.start_write);
        end
        wait_ack(50, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0001 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            n_err++;
            $display("FAIL rd_data: ack=%b data=%h err=%b want 0001/deadbeef/0", a, d, e);
        end
        n_chk++;
        if (n_sr - sr0 !== 1) begin
            n_err++;
            $display("FAIL rd_pulses: reads=%0d want 1", n_sr - sr0);
        end
    endtask

    task automatic test_contention();
        logic [3:0] a; logic [31:0] d; logic e; int c; logic [3:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'(4 * i), 32'h1000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            exp_a = 4'b0001 << i;
            wait_ack(50, 1'b0, a, d, e, c);
            n_chk++;
            if (a !== exp_a || e !== 1'b0) begin
                n_err++;
                $display("FAIL cont_order[%0d]: ack=%b err=%b want %b/0", i, a, e, exp_a);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_a = 4'b0001 << i;
            @(negedge clk);
            set_req(i, 1'b0, 32'(4 * i), 32'h0);
            wait_ack(50, 1'b0, a, d, e, c);
            n_chk++;
            if (a !== exp_a || d !== 32'h1000 + 32'(i)) begin
                n_err++;
                $display("FAIL cont_readback[%0d]: ack=%b data=%h want %b/%h", i, a, d, exp_a, 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] a; logic [31:0] d; logic e; int c; logic [3:0] exp_a; logic [31:0] exp_d;
        @(negedge clk);
        set_req(2, 1'b0, 32'h8, 32'h0);
        wait_ack(50, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0100 || d !== 32'h1002) begin
            n_err++;
            $display("FAIL fair_setup: ack=%b data=%h want 0100/00001002", a, d);
        end
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 32'h0);
        set_req(3, 1'b0, 32'hC, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0) ? 4'b1000 : 4'b0001;
            exp_d = (i % 2 == 0) ? 32'h1003 : 32'h1000;
            wait_ack(50, 1'b1, a, d, e, c);
            n_chk++;
            if (a !== exp_a || d !== exp_d) begin
                n_err++;
                $display("FAIL fair_order[%0d]: ack=%b data=%h want %b/%h", i, a, d, exp_a, exp_d);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [3:0] a; logic [31:0] d; logic e; int c; int bad;
        @(negedge clk);
        stub_hang = 1'b1;
        set_req(1, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bus.start_read !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_start: rd=%b want 1", bus.start_read);
        end
        wait_ack(200, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0010 || e !== 1'b1 || d !== 32'h0) begin
            n_err++;
            $display("FAIL tmo_ack: ack=%b err=%b data=%h want 0010/1/0", a, e, d);
        end
        n_chk++;
        if (c !== 65) begin
            n_err++;
            $display("FAIL tmo_latency: got %0d cycles want 65", c);
        end
        set_req(0, 1'b0, 32'h0, 32'h0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.start_read !== 1'b0 || bus.start_write !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL tmo_drain: %0d bad cycles want 0 (busy=1, no start)", bad);
        end
        stub_hang = 1'b0;
        tb_done   = 1'b1;
        @(negedge clk);
        tb_done   = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_release: busy=%b want 0", bus.busy);
        end
        @(negedge clk);
        n_chk++;
        if (bus.start_read !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_regrant: rd=%b want 1", bus.start_read);
        end
        wait_ack(50, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0001 || d !== 32'h1000 || e !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_after: ack=%b data=%h err=%b want 0001/00001000/0", a, d, e);
        end
    endtask

    task automatic test_coincident();
        logic [3:0] a; logic [31:0] d; logic e; int c;
        @(negedge clk);
        stub_lat = 62;
        set_req(2, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        wait_ack(200, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0100 || e !== 1'b0 || d !== 32'h1001 || c !== 65) begin
            n_err++;
            $display("FAIL coinc_ack: ack=%b err=%b data=%h cyc=%0d want 0100/0/00001001/65", a, e, d, c);
        end
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL coinc_nodrain: busy=%b want 0", bus.busy);
        end
        stub_lat = 2;
    endtask

    task automatic test_reset_mid();
        logic [3:0] a; logic [31:0] d; logic e; int c; int bad;
        @(negedge clk);
        stub_lat = 10;
        set_req(3, 1'b1, 32'hC, 32'h5555AAAA);
        repeat (4) @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy: busy=%b want 1", bus.busy);
        end
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({bus.ack, bus.busy, bus.start_read, bus.start_write, bus.rsp_err} !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_ctrl: ack=%b busy=%b rd=%b wr=%b err=%b want all 0",
                     bus.ack, bus.busy, bus.start_read, bus.start_write, bus.rsp_err);
        end
        n_chk++;
        if (bus.addr !== 32'h0 || bus.write_data !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_data: addr=%h wdata=%h rdata=%h want 0", bus.addr, bus.write_data, bus.rsp_rdata);
        end
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.ack !== '0 || bus.busy !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rstmid_noack: %0d cycles with ack/busy want 0", bad);
        end
        stub_lat = 2;
        set_req(1, 1'b0, 32'hC, 32'h0);
        wait_ack(50, 1'b0, a, d, e, c);
        n_chk++;
        if (a !== 4'b0010 || d !== 32'h1003 || e !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_clean: ack=%b data=%h err=%b want 0010/00001003/0", a, d, e);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_fairness();
        test_timeout();
        test_coincident();
        test_reset_mid();
        n_chk++;
        if (n_both !== 0) begin
            n_err++;
            $display("FAIL start_exclusive: %0d cycles with both starts want 0", n_both);
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
